// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin owner of the main-memory port for icache and dcache
//            line transfers, returning a one-cycle done pulse plus line data.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int CACHE_LINE_SIZE = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       icache_req_in,
    input  logic [ADDRESS_WIDTH-1:0]   icache_addr_in,
    input  logic                       dcache_req_in,
    input  logic                       dcache_write_in,
    input  logic [ADDRESS_WIDTH-1:0]   dcache_addr_in,
    input  logic [CACHE_LINE_SIZE-1:0] dcache_wdata_in,
    input  logic                       mem_ready_in,
    input  logic [CACHE_LINE_SIZE-1:0] mem_rdata_in,
    output logic                       mem_req_out,
    output logic                       mem_write_out,
    output logic [ADDRESS_WIDTH-1:0]   mem_addr_out,
    output logic [CACHE_LINE_SIZE-1:0] mem_wdata_out,
    output logic [CACHE_LINE_SIZE-1:0] rdata_out,
    output logic                       icache_done_out,
    output logic                       dcache_done_out,
    output logic                       busy_out
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ICACHE_XFER = 2'd1,
        S_DCACHE_XFER = 2'd2,
        S_DONE        = 2'd3
    } state_t;

    localparam logic c_grant_icache = 1'b0;
    localparam logic c_grant_dcache = 1'b1;

    state_t                       r_state,       w_state;
    logic                         r_last_grant,  w_last_grant;
    logic                         r_mem_req,     w_mem_req;
    logic                         r_mem_write,   w_mem_write;
    logic [ADDRESS_WIDTH-1:0]     r_mem_addr,    w_mem_addr;
    logic [CACHE_LINE_SIZE-1:0]   r_mem_wdata,   w_mem_wdata;
    logic [CACHE_LINE_SIZE-1:0]   r_rdata,       w_rdata;
    logic                         r_icache_done, w_icache_done;
    logic                         r_dcache_done, w_dcache_done;
    logic                         r_busy;
    logic                         w_busy;
    logic                         w_icache_wins;

    // On a tie the side that did not win last time takes the port.
    assign w_icache_wins = icache_req_in &&
                           (!dcache_req_in || (r_last_grant == c_grant_dcache));
    assign w_busy        = (w_state != S_IDLE);

    always_comb begin
        w_state       = r_state;
        w_last_grant  = r_last_grant;
        w_mem_req     = r_mem_req;
        w_mem_write   = r_mem_write;
        w_mem_addr    = r_mem_addr;
        w_mem_wdata   = r_mem_wdata;
        w_rdata       = r_rdata;
        w_icache_done = 1'b0;
        w_dcache_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_icache_wins) begin
                    w_state      = S_ICACHE_XFER;
                    w_last_grant = c_grant_icache;
                    w_mem_req    = 1'b1;
                    w_mem_write  = 1'b0;
                    w_mem_addr   = icache_addr_in;
                    w_mem_wdata  = '0;
                end else if (dcache_req_in) begin
                    w_state      = S_DCACHE_XFER;
                    w_last_grant = c_grant_dcache;
                    w_mem_req    = 1'b1;
                    w_mem_write  = dcache_write_in;
                    w_mem_addr   = dcache_addr_in;
                    w_mem_wdata  = dcache_wdata_in;
                end
            end
            S_ICACHE_XFER, S_DCACHE_XFER: begin
                if (mem_ready_in) begin
                    // Write-backs return no data, so the last read line is kept.
                    if (!r_mem_write) begin
                        w_rdata = mem_rdata_in;
                    end
                    w_mem_req     = 1'b0;
                    w_icache_done = (r_state == S_ICACHE_XFER);
                    w_dcache_done = (r_state == S_DCACHE_XFER);
                    w_state       = S_DONE;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= c_grant_dcache;
            r_mem_req     <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rdata       <= '0;
            r_icache_done <= 1'b0;
            r_dcache_done <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_last_grant  <= w_last_grant;
            r_mem_req     <= w_mem_req;
            r_mem_write   <= w_mem_write;
            r_mem_addr    <= w_mem_addr;
            r_mem_wdata   <= w_mem_wdata;
            r_rdata       <= w_rdata;
            r_icache_done <= w_icache_done;
            r_dcache_done <= w_dcache_done;
            r_busy        <= w_busy;
        end
    end

    assign mem_req_out     = r_mem_req;
    assign mem_write_out   = r_mem_write;
    assign mem_addr_out    = r_mem_addr;
    assign mem_wdata_out   = r_mem_wdata;
    assign rdata_out       = r_rdata;
    assign icache_done_out = r_icache_done;
    assign dcache_done_out = r_dcache_done;
    assign busy_out        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter: directed transfers push
//            expected grants/completions, a negedge monitor pops and compares.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;

    localparam logic [LW-1:0] c_line1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [LW-1:0] c_ones  = 128'h11111111_11111111_11111111_11111111;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } grant_t;

    typedef struct packed {
        logic          side;
        logic [LW-1:0] rd;
    } done_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_req_in;
    logic [AW-1:0] icache_addr_in;
    logic          dcache_req_in;
    logic          dcache_write_in;
    logic [AW-1:0] dcache_addr_in;
    logic [LW-1:0] dcache_wdata_in;
    logic          mem_ready_in;
    logic [LW-1:0] mem_rdata_in;
    logic          mem_req_out;
    logic          mem_write_out;
    logic [AW-1:0] mem_addr_out;
    logic [LW-1:0] mem_wdata_out;
    logic [LW-1:0] rdata_out;
    logic          icache_done_out;
    logic          dcache_done_out;
    logic          busy_out;

    mem_port_arbiter #(
        .ADDRESS_WIDTH   (AW),
        .CACHE_LINE_SIZE (LW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .icache_req_in   (icache_req_in),
        .icache_addr_in  (icache_addr_in),
        .dcache_req_in   (dcache_req_in),
        .dcache_write_in (dcache_write_in),
        .dcache_addr_in  (dcache_addr_in),
        .dcache_wdata_in (dcache_wdata_in),
        .mem_ready_in    (mem_ready_in),
        .mem_rdata_in    (mem_rdata_in),
        .mem_req_out     (mem_req_out),
        .mem_write_out   (mem_write_out),
        .mem_addr_out    (mem_addr_out),
        .mem_wdata_out   (mem_wdata_out),
        .rdata_out       (rdata_out),
        .icache_done_out (icache_done_out),
        .dcache_done_out (dcache_done_out),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    grant_t        exp_grant_q[$];
    done_t         exp_done_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [LW-1:0] model_rdata = '0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        grant_t g;
        g.w = w;
        g.a = a;
        g.d = d;
        exp_grant_q.push_back(g);
    endtask

    // Completion expectation; write-backs expect the previous read line.
    task automatic exp_done(input logic side, input logic w, input logic [LW-1:0] rd);
        done_t d;
        if (!w) model_rdata = rd;
        d.side = side;
        d.rd   = model_rdata;
        exp_done_q.push_back(d);
    endtask

    task automatic serve(input int k, input logic [LW-1:0] rd, input string name);
        int n = 0;
        while (!mem_req_out && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_grant_wait"}, LW'(mem_req_out), LW'(1));
        repeat (k - 1) tick();
        mem_ready_in = 1'b1;
        mem_rdata_in = rd;
        tick();
        mem_ready_in = 1'b0;
        mem_rdata_in = ~rd;
    endtask

    task automatic clear_inputs();
        icache_req_in   = 1'b0;
        icache_addr_in  = '0;
        dcache_req_in   = 1'b0;
        dcache_write_in = 1'b0;
        dcache_addr_in  = '0;
        dcache_wdata_in = '0;
        mem_ready_in    = 1'b0;
        mem_rdata_in    = '0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_mem_req"},   LW'(mem_req_out),     '0);
        chk({name, "_mem_write"}, LW'(mem_write_out),   '0);
        chk({name, "_mem_addr"},  LW'(mem_addr_out),    '0);
        chk({name, "_mem_wdata"}, mem_wdata_out,        '0);
        chk({name, "_rdata"},     rdata_out,            '0);
        chk({name, "_idone"},     LW'(icache_done_out), '0);
        chk({name, "_ddone"},     LW'(dcache_done_out), '0);
        chk({name, "_busy"},      LW'(busy_out),        '0);
    endtask

    // Monitor: checks every new grant, transfer stability and every done pulse.
    logic          prev_req   = 1'b0;
    logic          prev_write = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [LW-1:0] prev_wdata = '0;

    always @(negedge clk) begin
        grant_t g;
        done_t  d;
        if (mem_req_out && !prev_req) begin
            if (exp_grant_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got addr %h expected no grant", mem_addr_out);
            end else begin
                g = exp_grant_q.pop_front();
                chk("grant_addr",  LW'(mem_addr_out),  LW'(g.a));
                chk("grant_write", LW'(mem_write_out), LW'(g.w));
                if (g.w) chk("grant_wdata", mem_wdata_out, g.d);
            end
        end else if (mem_req_out && prev_req) begin
            chk("stable_addr",  LW'(mem_addr_out),  LW'(prev_addr));
            chk("stable_write", LW'(mem_write_out), LW'(prev_write));
            chk("stable_wdata", mem_wdata_out,      prev_wdata);
        end
        if (icache_done_out || dcache_done_out) begin
            chk("done_exclusive", LW'(icache_done_out & dcache_done_out), '0);
            if (exp_done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got idone=%0b ddone=%0b expected none",
                         icache_done_out, dcache_done_out);
            end else begin
                d = exp_done_q.pop_front();
                chk("done_side",  LW'(dcache_done_out), LW'(d.side));
                chk("done_rdata", rdata_out,            d.rd);
            end
        end
        prev_req   = mem_req_out;
        prev_write = mem_write_out;
        prev_addr  = mem_addr_out;
        prev_wdata = mem_wdata_out;
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // icache refill, ready three cycles after the grant
        exp_grant(1'b0, 32'h0000_0040, '0);
        exp_done(1'b0, 1'b0, c_line1);
        icache_req_in  = 1'b1;
        icache_addr_in = 32'h0000_0040;
        tick();
        chk("t1_req_rise", LW'(mem_req_out), LW'(1));
        chk("t1_busy",     LW'(busy_out),    LW'(1));
        tick();
        tick();
        chk("t1_req_hold", LW'(mem_req_out), LW'(1));
        mem_ready_in = 1'b1;
        mem_rdata_in = c_line1;
        tick();
        mem_ready_in  = 1'b0;
        mem_rdata_in  = '0;
        icache_req_in = 1'b0;
        chk("t1_req_clear", LW'(mem_req_out),     '0);
        chk("t1_idone",     LW'(icache_done_out), LW'(1));
        chk("t1_rdata",     rdata_out,            c_line1);
        chk("t1_busy_done", LW'(busy_out),        LW'(1));
        tick();
        chk("t1_idone_fall", LW'(icache_done_out), '0);
        chk("t1_busy_idle",  LW'(busy_out),        '0);

        // reset restores last_grant to dcache, so icache must win the first tie
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_rdata = '0;
        exp_grant(1'b0, 32'h0000_1000, '0);
        exp_done(1'b0, 1'b0, 128'hA0);
        exp_grant(1'b0, 32'h0000_2000, '0);
        exp_done(1'b1, 1'b0, 128'hB0);
        exp_grant(1'b0, 32'h0000_1000, '0);
        exp_done(1'b0, 1'b0, 128'hA1);
        exp_grant(1'b0, 32'h0000_2000, '0);
        exp_done(1'b1, 1'b0, 128'hB1);
        icache_req_in  = 1'b1;
        icache_addr_in = 32'h0000_1000;
        dcache_req_in  = 1'b1;
        dcache_addr_in = 32'h0000_2000;
        serve(1, 128'hA0, "rr0");
        serve(1, 128'hB0, "rr1");
        serve(1, 128'hA1, "rr2");
        serve(1, 128'hB1, "rr3");
        icache_req_in = 1'b0;
        dcache_req_in = 1'b0;
        tick();
        tick();
        chk("rr_idle_req", LW'(mem_req_out), '0);

        // reset in the middle of a dcache transfer, with ready on the same edge
        exp_grant(1'b0, 32'h0000_3000, '0);
        dcache_req_in  = 1'b1;
        dcache_addr_in = 32'h0000_3000;
        tick();
        icache_req_in  = 1'b1;
        icache_addr_in = 32'h0000_4000;
        tick();
        reset        = 1'b1;
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'hFACE;
        tick();
        check_all_zero("rst_mid");
        model_rdata = '0;
        exp_grant(1'b0, 32'h0000_4000, '0);
        exp_done(1'b0, 1'b0, 128'hC0);
        exp_grant(1'b0, 32'h0000_3000, '0);
        exp_done(1'b1, 1'b0, 128'hD0);
        reset        = 1'b0;
        mem_ready_in = 1'b0;
        serve(2, 128'hC0, "rst_i");
        icache_req_in = 1'b0;
        serve(1, 128'hD0, "rst_d");
        dcache_req_in = 1'b0;
        tick();

        // stray ready while idle
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'hBAD0;
        tick();
        mem_ready_in = 1'b0;
        chk("idle_ready_req",   LW'(mem_req_out), '0);
        chk("idle_ready_busy",  LW'(busy_out),    '0);
        chk("idle_ready_rdata", rdata_out,        model_rdata);
        tick();
        chk("idle_ready_busy2", LW'(busy_out),    '0);

        // dcache write-back leaves rdata_out untouched
        exp_grant(1'b1, 32'h0000_0100, c_ones);
        exp_done(1'b1, 1'b1, '0);
        dcache_req_in   = 1'b1;
        dcache_write_in = 1'b1;
        dcache_addr_in  = 32'h0000_0100;
        dcache_wdata_in = c_ones;
        tick();
        chk("wb_write", LW'(mem_write_out), LW'(1));
        chk("wb_wdata", mem_wdata_out,      c_ones);
        dcache_wdata_in = '0;
        tick();
        chk("wb_wdata_hold", mem_wdata_out, c_ones);
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'hBAD1;
        tick();
        mem_ready_in    = 1'b0;
        dcache_req_in   = 1'b0;
        dcache_write_in = 1'b0;
        chk("wb_ddone", LW'(dcache_done_out), LW'(1));
        chk("wb_rdata", rdata_out,            model_rdata);
        tick();

        // requester drops req right after the grant; transfer still completes
        exp_grant(1'b0, 32'h0000_0200, '0);
        exp_done(1'b1, 1'b0, 128'h5A5A);
        dcache_req_in  = 1'b1;
        dcache_addr_in = 32'h0000_0200;
        tick();
        tick();
        dcache_req_in = 1'b0;
        repeat (3) tick();
        chk("drop_req_hold", LW'(mem_req_out), LW'(1));
        mem_ready_in = 1'b1;
        mem_rdata_in = 128'h5A5A;
        tick();
        mem_ready_in = 1'b0;
        chk("drop_ddone", LW'(dcache_done_out), LW'(1));
        tick();
        chk("drop_busy_idle", LW'(busy_out), '0);
        tick();
        chk("drop_no_regrant", LW'(mem_req_out), '0);

        tick();
        chk("grant_queue_empty", LW'(exp_grant_q.size()), '0);
        chk("done_queue_empty",  LW'(exp_done_q.size()),  '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single main-memory port between instruction-cache and data-cache line requests (refill reads, write-back writes).
- Sequences each transfer as a req/ready handshake to memory and returns a one-cycle completion pulse plus line data to the winning cache.
- Sits between the caches and main memory. The data-cache completion pulse feeds the dcache_op_done path toward the memory-stage pipeline registers.

Parameters:
- ADDRESS_WIDTH, 32, byte address width of a line request.
- CACHE_LINE_SIZE, 128, line width in bits for read and write data.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- icache_req_in  in  1  icache requests a line read; held until icache_done_out.
- icache_addr_in  in  ADDRESS_WIDTH  icache line address.
- dcache_req_in  in  1  dcache requests a transfer; held until dcache_done_out.
- dcache_write_in  in  1  1 = write-back, 0 = refill read.
- dcache_addr_in  in  ADDRESS_WIDTH  dcache line address.
- dcache_wdata_in  in  CACHE_LINE_SIZE  line written on write-back.
- mem_ready_in  in  1  memory completes the current operation (single-cycle pulse).
- mem_rdata_in  in  CACHE_LINE_SIZE  read line, valid with mem_ready_in.
- mem_req_out  out  1  memory operation active.
- mem_write_out  out  1  operation is a write.
- mem_addr_out  out  ADDRESS_WIDTH  operation address.
- mem_wdata_out  out  CACHE_LINE_SIZE  write line.
- rdata_out  out  CACHE_LINE_SIZE  last read line; valid while a done pulse is high.
- icache_done_out  out  1  one-cycle completion pulse to icache.
- dcache_done_out  out  1  one-cycle completion pulse to dcache.
- busy_out  out  1  arbiter not in IDLE.

Behaviour:
- Reset (sync, high): state=IDLE, last_grant=DCACHE (so icache wins the first tie). All outputs are 0, including rdata_out, mem_addr_out and mem_wdata_out. Reset takes priority over every other event, including mid-transfer; no done pulse is issued for an aborted transfer.
- States: IDLE, ICACHE_XFER, DCACHE_XFER, DONE.
- IDLE:
  - Only icache_req_in high: go to ICACHE_XFER.
  - Only dcache_req_in high: go to DCACHE_XFER.
  - Both high: grant the requester not equal to last_grant (round-robin).
  - On the grant edge, register addr, write flag and wdata into the mem_* outputs, assert mem_req_out, and update last_grant.
- ICACHE_XFER / DCACHE_XFER:
  - Hold mem_req_out=1 and keep mem_addr_out, mem_write_out and mem_wdata_out stable.
  - Wait for mem_ready_in. On that edge: capture mem_rdata_in into rdata_out (reads only; writes leave rdata_out unchanged), clear mem_req_out, pulse the matching done output for exactly one cycle, and go to DONE.
- DONE:
  - One bubble cycle; done pulse falls. Lets the requester drop its req before re-arbitration.
  - Always returns to IDLE. Requests sampled in DONE are ignored.
- Minimum latency: req high at edge N gives mem_req_out high after edge N. With mem_ready_in at edge N+k (k≥1), done is high during cycle N+k and the next grant is no earlier than edge N+k+2.
- Unmodified requests:
  - mem_ready_in while in IDLE or DONE is ignored.
  - A requester dropping req mid-transfer does not abort it; the transfer completes and the done pulse is still issued.
- icache transfers always have mem_write_out=0.
- busy_out = (state != IDLE), registered alongside the state.
- icache_done_out and dcache_done_out are never high in the same cycle.

Test Plan:
- Reset, then icache_req_in=1 with addr 0x0000_0040. mem_ready_in after 3 cycles with rdata 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D -> mem_req_out high for 3 cycles with addr 0x40 and write=0; icache_done_out one-cycle pulse; rdata_out equals the line; busy_out drops 2 cycles after ready.
- dcache write-back: addr 0x100, wdata 0x1111...1111, write=1 -> mem_write_out=1 and mem_wdata_out stable until ready; dcache_done_out pulse; rdata_out unchanged.
- Both requests held continuously, ready 1 cycle after each req -> grants alternate I, D, I, D (first icache after reset); no two consecutive same-side grants.
- Reset asserted mid-DCACHE_XFER, then mem_ready_in arrives -> next cycle all outputs 0, no done pulse, ready ignored; after release a pending icache req is granted first.
- mem_ready_in pulsed while IDLE, with no requests -> no state change, no done pulses, mem_req_out stays 0.
- dcache_req_in dropped one cycle after grant, ready 4 cycles later -> transfer completes, dcache_done_out still pulses once, returns to IDLE.
